// File: rtl/fix_frame_encoder.sv
// FIX frame encoder. Picks one body source round-robin, then streams a complete frame:
// "8=<BEGIN_STR>SOH 9=<len>SOH <body> 10=<ccc>SOH", computing BodyLength and CheckSum on the fly.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no frame in flight; arbitrate, latch body, pulse src_ready
//   ST_BEGIN | emitting "8=", BeginString, SOH
//   ST_BLEN  | emitting "9=", decimal body length (no leading zeros), SOH
//   ST_BODY  | emitting latched body bytes, index 0 first
//   ST_CSUM  | emitting "10=", three checksum digits, SOH with m_last
module fix_frame_encoder #(
  parameter int                     N_SRC     = 2,
  parameter int                     MAX_BODY  = 256,
  parameter int                     BEGIN_LEN = 7,
  parameter logic [BEGIN_LEN*8-1:0] BEGIN_STR = "FIX.4.4",
  localparam int                    LW        = $clog2(MAX_BODY + 1),
  localparam int                    SW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_SRC-1:0]            src_valid,
  output logic [N_SRC-1:0]            src_ready,
  input  logic [N_SRC*MAX_BODY*8-1:0] src_body,
  input  logic [N_SRC*LW-1:0]         src_len,
  output logic [7:0]                  m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic [SW-1:0]               m_src,
  output logic                        err_len
);

  // Byte index must cover the longest field: the body or the BeginString field.
  localparam int IW = $clog2(MAX_BODY + BEGIN_LEN + 3);
  localparam logic [7:0] SOH = 8'h01;

  typedef enum logic [2:0] {ST_IDLE, ST_BEGIN, ST_BLEN, ST_BODY, ST_CSUM} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [7:0]              csum_q, csum_d;
  logic [SW-1:0]           ptr_q, ptr_d;
  logic [SW-1:0]           src_q, src_d;
  logic [LW-1:0]           len_q, len_d;
  logic [MAX_BODY*8-1:0]   body_q, body_d;

  logic                    found;
  logic [SW-1:0]           gnt;
  int                      cand;
  logic [LW-1:0]           gnt_len;
  logic                    len_bad;

  logic [7:0]              cur_byte;
  logic                    end_st;
  logic [7:0]              len_dig [3];
  logic [7:0]              cs_dig  [3];
  int                      ndig;
  int                      k;

  assign m_src = src_q;

  // Round-robin pick: lowest valid index at or above the pointer, wrapping to 0.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = 0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = (int'(ptr_q) + i) % N_SRC;
      if (!found && src_valid[cand]) begin
        found = 1'b1;
        gnt   = SW'(cand);
      end
    end
    gnt_len = src_len[int'(gnt)*LW +: LW];
    len_bad = (gnt_len == '0) || (int'(gnt_len) > MAX_BODY);
  end

  // Frame byte for the current state/index, and whether it closes its field.
  always_comb begin
    len_dig[0] = 8'h30 + 8'(int'(len_q) / 100);
    len_dig[1] = 8'h30 + 8'((int'(len_q) / 10) % 10);
    len_dig[2] = 8'h30 + 8'(int'(len_q) % 10);
    cs_dig[0]  = 8'h30 + 8'(int'(csum_q) / 100);
    cs_dig[1]  = 8'h30 + 8'((int'(csum_q) / 10) % 10);
    cs_dig[2]  = 8'h30 + 8'(int'(csum_q) % 10);
    ndig       = (int'(len_q) >= 100) ? 3 : (int'(len_q) >= 10) ? 2 : 1;
    k          = int'(idx_q);
    cur_byte   = 8'h00;
    end_st     = 1'b0;
    case (state_q)
      ST_BEGIN: begin
        if (k == 0)                  cur_byte = "8";
        else if (k == 1)             cur_byte = "=";
        else if (k <= BEGIN_LEN + 1) cur_byte = BEGIN_STR[(BEGIN_LEN + 1 - k)*8 +: 8];
        else begin
          cur_byte = SOH;
          end_st   = 1'b1;
        end
      end
      ST_BLEN: begin
        if (k == 0)                  cur_byte = "9";
        else if (k == 1)             cur_byte = "=";
        else if (k - 2 < ndig)       cur_byte = len_dig[3 - ndig + k - 2];
        else begin
          cur_byte = SOH;
          end_st   = 1'b1;
        end
      end
      ST_BODY: begin
        cur_byte = body_q[k*8 +: 8];
        end_st   = (k == int'(len_q) - 1);
      end
      ST_CSUM: begin
        if (k == 0)                  cur_byte = "1";
        else if (k == 1)             cur_byte = "0";
        else if (k == 2)             cur_byte = "=";
        else if (k <= 5)             cur_byte = cs_dig[k - 3];
        else begin
          cur_byte = SOH;
          end_st   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next-state, grant and stream outputs; everything advances only on a byte handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    ptr_d     = ptr_q;
    src_d     = src_q;
    len_d     = len_q;
    body_d    = body_q;
    src_ready = '0;
    err_len   = 1'b0;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_last    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (found) begin
        src_ready[gnt] = 1'b1;
        ptr_d          = SW'((int'(gnt) + 1) % N_SRC);
        csum_d         = 8'h00;
        idx_d          = '0;
        if (len_bad) begin
          err_len = 1'b1;
        end else begin
          body_d  = src_body[int'(gnt)*MAX_BODY*8 +: MAX_BODY*8];
          len_d   = gnt_len;
          src_d   = gnt;
          state_d = ST_BEGIN;
        end
      end
    end else begin
      m_valid = 1'b1;
      m_data  = cur_byte;
      m_last  = (state_q == ST_CSUM) && end_st;
      if (m_ready) begin
        // Checksum covers everything before the "10=" field.
        if (state_q != ST_CSUM) csum_d = csum_q + cur_byte;
        if (end_st) begin
          idx_d = '0;
          case (state_q)
            ST_BEGIN: state_d = ST_BLEN;
            ST_BLEN:  state_d = ST_BODY;
            ST_BODY:  state_d = ST_CSUM;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
    end
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      ptr_q   <= '0;
      src_q   <= '0;
      len_q   <= '0;
      body_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      len_q   <= len_d;
      body_q  <= body_d;
    end
  end

endmodule
